// File: rtl/memory_burst_responder.sv
// Burst memory responder: serves 32-beat line refills and write-backs against a
// 2^(ADDR_BITS-2) x 32-bit synchronous array with a programmable read latency.
module memory_burst_responder #(
  parameter int unsigned ADDR_BITS = 12,
  parameter int unsigned LATENCY   = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] mem_addr,
  input  logic        mem_read_req,
  input  logic        mem_write_en,
  input  logic [7:0]  mem_data_in  [0:3],
  output logic [7:0]  mem_data_out [0:3],
  output logic        mem_valid,
  output logic        mem_busy,
  output logic        mem_done
);

  localparam int unsigned LineBits = ADDR_BITS - 7;
  localparam int unsigned WordBits = ADDR_BITS - 2;
  localparam int unsigned Depth    = 2 ** WordBits;
  // RD_WAIT spends LATENCY-1 edges before loading beat 0.
  localparam logic [3:0]  LatInit  = (LATENCY >= 2) ? 4'(LATENCY - 2) : 4'd0;

  typedef enum logic [1:0] {StIdle, StRdWait, StRdBurst, StWrBurst} state_e;

  state_e              r_state;
  logic [LineBits-1:0] r_base;
  logic [4:0]          r_beat;
  logic [3:0]          r_lat;
  logic [31:0]         r_data;
  logic                r_valid;
  logic                r_busy;
  logic                r_done;
  logic [31:0]         r_mem [Depth];

  logic [LineBits-1:0] w_line;
  logic [4:0]          w_next_beat;
  logic                w_we;
  logic [WordBits-1:0] w_waddr;
  logic [31:0]         w_wdata;
  logic                w_unused_addr;

  assign w_line        = mem_addr[ADDR_BITS-1:7];
  assign w_unused_addr = ^{mem_addr[31:ADDR_BITS], mem_addr[6:0]};
  assign w_next_beat   = r_beat + 5'd1;
  assign w_wdata       = {mem_data_in[3], mem_data_in[2], mem_data_in[1], mem_data_in[0]};

  // Writes land only on beats the FSM consumes; a held reset blocks them too.
  assign w_we    = rst && mem_write_en && ((r_state == StIdle) || (r_state == StWrBurst));
  assign w_waddr = (r_state == StIdle) ? {w_line, 5'd0} : {r_base, r_beat};

  // Array has no reset so committed words survive a mid-burst reset.
  always_ff @(posedge clk) begin
    if (w_we) begin
      r_mem[w_waddr] <= w_wdata;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= StIdle;
      r_base  <= '0;
      r_beat  <= '0;
      r_lat   <= '0;
      r_data  <= '0;
      r_valid <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      unique case (r_state)
        StIdle: begin
          if (mem_write_en) begin
            r_state <= StWrBurst;
            r_base  <= w_line;
            r_beat  <= 5'd1;
            r_busy  <= 1'b1;
          end else if (mem_read_req) begin
            r_base <= w_line;
            r_beat <= '0;
            r_busy <= 1'b1;
            if (LATENCY <= 1) begin
              r_state <= StRdBurst;
              r_valid <= 1'b1;
              r_data  <= r_mem[{w_line, 5'd0}];
            end else begin
              r_state <= StRdWait;
              r_lat   <= LatInit;
            end
          end
        end
        StRdWait: begin
          if (r_lat == '0) begin
            r_state <= StRdBurst;
            r_valid <= 1'b1;
            r_data  <= r_mem[{r_base, 5'd0}];
          end else begin
            r_lat <= r_lat - 4'd1;
          end
        end
        StRdBurst: begin
          if (r_beat == 5'd31) begin
            r_state <= StIdle;
            r_beat  <= '0;
            r_valid <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
          end else begin
            r_beat <= w_next_beat;
            r_data <= r_mem[{r_base, w_next_beat}];
          end
        end
        StWrBurst: begin
          if (mem_write_en) begin
            if (r_beat == 5'd31) begin
              r_state <= StIdle;
              r_beat  <= '0;
              r_busy  <= 1'b0;
              r_done  <= 1'b1;
            end else begin
              r_beat <= w_next_beat;
            end
          end
        end
        default: r_state <= StIdle;
      endcase
    end
  end

  assign mem_data_out[0] = r_data[7:0];
  assign mem_data_out[1] = r_data[15:8];
  assign mem_data_out[2] = r_data[23:16];
  assign mem_data_out[3] = r_data[31:24];
  assign mem_valid       = r_valid;
  assign mem_busy        = r_busy;
  assign mem_done        = r_done;

endmodule
